// File: rtl/uart_rx_framer.sv
// uart_rx_framer: oversampling UART receiver for the FTDI RX line.
// Synchronises rxd, takes three samples around mid-bit and keeps the 2-of-3
// majority, then hands completed bytes to the command processor over
// valid/ready. Framing, overrun and (optionally) parity errors are reported
// as one-cycle pulses so corrupted command frames can be discarded.
//
// Build option: define UART_RX_PARITY_EN for 8E1 framing (even parity bit
// after bit 7, parity_err live). Left undefined the frame is 8N1 and
// parity_err is tied low.
`timescale 1ns/1ps

module uart_rx_framer #(
  parameter int CLKS_PER_BIT = 868,
  parameter int SYNC_STAGES  = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxd,
  output logic [7:0] dout,
  output logic       dout_valid,
  input  logic       dout_ready,
  output logic       busy,
  output logic       framing_err,
  output logic       overrun_err,
  output logic       parity_err
);

  // Bit-timing landmarks within one bit period (counter runs 0..LAST).
  localparam logic [15:0] CNT_LAST = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0] CNT_S0   = 16'(CLKS_PER_BIT / 2 - 1);
  localparam logic [15:0] CNT_S1   = 16'(CLKS_PER_BIT / 2);
  localparam logic [15:0] CNT_VOTE = 16'(CLKS_PER_BIT / 2 + 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    BREAK  = 3'd5
  } state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rxs;
  logic [15:0]            cnt;
  logic [2:0]             bit_idx;
  logic                   s0;
  logic                   s1;
  logic                   vote;
  logic                   at_vote;
  logic                   at_wrap;
  logic [7:0]             shreg;
  logic                   parity_ok;

`ifdef UART_RX_PARITY_EN
  logic par_bit;
  logic parity_q;
  // Even parity: data bits plus parity bit must XOR to zero.
  assign parity_ok  = ~(^{shreg, par_bit});
  assign parity_err = parity_q;
`else
  assign parity_ok  = 1'b1;
  assign parity_err = 1'b0;
`endif

  // Synchronise the asynchronous line; idle-high so reset loads ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], rxd};
    end
  end

  assign rxs = sync_q[SYNC_STAGES-1];

  // Majority of the samples at H-1, H and the live sample at H+1.
  always_comb begin
    vote    = (s0 & s1) | (s0 & rxs) | (s1 & rxs);
    at_vote = (cnt == CNT_VOTE);
    at_wrap = (cnt == CNT_LAST);
  end

  assign busy = (state != IDLE);

  // Handshake: dout_valid high means dout holds an unconsumed byte and dout is
  // frozen; the byte is taken on any clock edge where dout_valid and
  // dout_ready are both high, and dout_valid drops on the following cycle
  // unless a new byte completes on that same edge.

  // Receive FSM with bit counter, shift register and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      bit_idx     <= '0;
      s0          <= 1'b1;
      s1          <= 1'b1;
      shreg       <= '0;
      dout        <= '0;
      dout_valid  <= 1'b0;
      framing_err <= 1'b0;
      overrun_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bit     <= 1'b0;
      parity_q    <= 1'b0;
`endif
    end else begin
      framing_err <= 1'b0;
      overrun_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_q    <= 1'b0;
`endif
      if (dout_valid && dout_ready) begin
        dout_valid <= 1'b0;
      end

      if (state != IDLE) begin
        cnt <= at_wrap ? '0 : cnt + 16'd1;
        if (cnt == CNT_S0) s0 <= rxs;
        if (cnt == CNT_S1) s1 <= rxs;
      end

      case (state)
        IDLE: begin
          cnt     <= '0;
          bit_idx <= '0;
          // The cycle that sees the falling edge is count 0 of the start bit.
          if (!rxs) begin
            state <= START;
            cnt   <= 16'd1;
          end
        end

        START: begin
          if (at_vote && vote) begin
            // Line was back high at mid-bit: a glitch, not a start bit.
            state <= IDLE;
            cnt   <= '0;
          end else if (at_wrap) begin
            state <= DATA;
          end
        end

        DATA: begin
          if (at_vote) begin
            shreg <= {vote, shreg[7:1]};
          end
          if (at_wrap) begin
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              state <= PARITY;
`else
              state <= STOP;
`endif
            end
          end
        end

`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (at_vote) begin
            par_bit <= vote;
          end
          if (at_wrap) begin
            state <= STOP;
          end
        end
`endif

        STOP: begin
          if (at_vote) begin
            if (vote) begin
              // Leave at mid-stop so a back-to-back start edge is caught.
              state <= IDLE;
              cnt   <= '0;
              if (!parity_ok) begin
`ifdef UART_RX_PARITY_EN
                parity_q <= 1'b1;
`endif
              end else if (dout_valid && !dout_ready) begin
                overrun_err <= 1'b1;
              end else begin
                dout       <= shreg;
                dout_valid <= 1'b1;
              end
            end else begin
              framing_err <= 1'b1;
              state       <= BREAK;
            end
          end
        end

        BREAK: begin
          // Hold here while the line stays low so a break reports once.
          if (rxs) begin
            state <= IDLE;
            cnt   <= '0;
          end
        end

        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_framer.sv
// tb_uart_rx_framer: self-checking bench for uart_rx_framer at CLKS_PER_BIT=16.
// Table of single frames, hand-written corner sequences (glitch, break,
// overrun, reset mid-frame, parity) and a randomized frame stream checked
// against a frame-level outcome model and an expected-byte queue.
`timescale 1ns/1ps

module tb_uart_rx_framer;

  localparam int CPB = 16;
  localparam int H   = CPB / 2;
`ifdef UART_RX_PARITY_EN
  localparam int STOP_IDX = 10;
`else
  localparam int STOP_IDX = 9;
`endif
  // Posedge (counted from the negedge that drives the start bit) on which the
  // stop-bit vote is registered: 2 synchroniser edges, 1 edge to enter START,
  // then STOP_IDX whole bits plus H+1 counts.
  localparam int STOP_VOTE_EDGE = 3 + STOP_IDX * CPB + H + 1;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst;
  logic       rxd;
  logic [7:0] dout;
  logic       dout_valid;
  logic       dout_ready;
  logic       busy;
  logic       framing_err;
  logic       overrun_err;
  logic       parity_err;

  always #5 clk = ~clk;

  uart_rx_framer #(
    .CLKS_PER_BIT(CPB),
    .SYNC_STAGES (2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .rxd        (rxd),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .busy       (busy),
    .framing_err(framing_err),
    .overrun_err(overrun_err),
    .parity_err (parity_err)
  );

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int         n_vec = 0;
  int         n_err = 0;
  int         fr_cnt = 0;
  int         ov_cnt = 0;
  int         par_cnt = 0;
  int         hs_cnt = 0;
  logic [7:0] exp_q[$];
`ifdef UART_RX_PARITY_EN
  logic       par_flip = 1'b0;
`endif

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Count pulses and score every consumed byte against the expected queue.
  always @(negedge clk) begin
    if (!rst) begin
      if (framing_err) fr_cnt++;
      if (overrun_err) ov_cnt++;
      if (parity_err)  par_cnt++;
      if (dout_valid && dout_ready) begin
        hs_cnt++;
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_byte: got 0x%0h expected none at %0t", dout, $time);
        end else begin
          check("scoreboard_byte", 32'(dout), 32'(exp_q.pop_front()));
        end
      end
    end
  end

  // ---------------- driver tasks (enter and leave on a negedge) ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic b);
    rxd = b;
    tick(CPB);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_b);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    send_bit((^d) ^ par_flip);
`endif
    send_bit(stop_b);
  endtask

  task automatic set_ready(input logic v);
    @(posedge clk);
    #1 dout_ready = v;
    @(negedge clk);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [7:0] data;
    logic       stop_b;
    int         gap;
    logic       exp_byte;
    int         exp_fr;
  } vec_t;

  vec_t       vecs[8];
  logic [7:0] last_good;
  int         b_hs, b_fr, b_ov, b_par;

  task automatic snap();
    b_hs  = hs_cnt;
    b_fr  = fr_cnt;
    b_ov  = ov_cnt;
    b_par = par_cnt;
  endtask

  initial begin
    vecs[0] = '{8'h55, 1'b1, 0, 1'b1, 0};
    vecs[1] = '{8'hA3, 1'b1, 2, 1'b1, 0};
    vecs[2] = '{8'h00, 1'b1, 1, 1'b1, 0};
    vecs[3] = '{8'hFF, 1'b1, 1, 1'b1, 0};
    vecs[4] = '{8'h3C, 1'b0, 2, 1'b0, 1};
    vecs[5] = '{8'h81, 1'b1, 1, 1'b1, 0};
    vecs[6] = '{8'h7E, 1'b0, 2, 1'b0, 1};
    vecs[7] = '{8'hC5, 1'b1, 2, 1'b1, 0};

    rst        = 1'b1;
    rxd        = 1'b1;
    dout_ready = 1'b1;
    tick(3);
    check("rst_dout",        32'(dout),        32'h00);
    check("rst_dout_valid",  32'(dout_valid),  32'h0);
    check("rst_busy",        32'(busy),        32'h0);
    check("rst_framing_err", 32'(framing_err), 32'h0);
    check("rst_overrun_err", 32'(overrun_err), 32'h0);
    check("rst_parity_err",  32'(parity_err),  32'h0);
    rst = 1'b0;
    tick(2 * CPB);
    check("post_rst_busy",  32'(busy),       32'h0);
    check("post_rst_valid", 32'(dout_valid), 32'h0);

    // Table: first two entries are back-to-back (gap 0) with ready held high.
    last_good = 8'h00;
    for (int v = 0; v < 8; v++) begin
      snap();
      if (vecs[v].exp_byte) begin
        exp_q.push_back(vecs[v].data);
        last_good = vecs[v].data;
      end
      send_frame(vecs[v].data, vecs[v].stop_b);
      for (int g = 0; g < vecs[v].gap; g++) send_bit(1'b1);
      check($sformatf("vec%0d_bytes", v),   32'(hs_cnt - b_hs), 32'(vecs[v].exp_byte));
      check($sformatf("vec%0d_framing", v), 32'(fr_cnt - b_fr), 32'(vecs[v].exp_fr));
      check($sformatf("vec%0d_overrun", v), 32'(ov_cnt - b_ov), 32'h0);
      check($sformatf("vec%0d_dout", v),    32'(dout),          32'(last_good));
      check($sformatf("vec%0d_valid", v),   32'(dout_valid),    32'h0);
    end
    check("table_queue_empty", 32'(exp_q.size()), 32'h0);

    // Short low glitch: START is entered, then abandoned at the vote.
    snap();
    rxd = 1'b0;
    tick(4);
    check("glitch_busy_in_start", 32'(busy), 32'h1);
    tick(1);
    rxd = 1'b1;
    tick(30);
    check("glitch_busy_after", 32'(busy),            32'h0);
    check("glitch_bytes",      32'(hs_cnt - b_hs),   32'h0);
    check("glitch_framing",    32'(fr_cnt - b_fr),   32'h0);

    // Bad stop then a held-low line: one framing pulse, busy until release.
    snap();
    send_frame(8'h3C, 1'b0);
    rxd = 1'b0;
    tick(40);
    check("break_busy_held", 32'(busy),          32'h1);
    check("break_framing",   32'(fr_cnt - b_fr), 32'h1);
    check("break_bytes",     32'(hs_cnt - b_hs), 32'h0);
    check("break_valid",     32'(dout_valid),    32'h0);
    rxd = 1'b1;
    tick(5);
    check("break_busy_released", 32'(busy),          32'h0);
    check("break_framing_once",  32'(fr_cnt - b_fr), 32'h1);
    send_bit(1'b1);

    // Overrun: consumer stalled across two frames.
    set_ready(1'b0);
    snap();
    exp_q.push_back(8'h11);
    send_frame(8'h11, 1'b1);
    send_bit(1'b1);
    check("ovr_first_valid", 32'(dout_valid), 32'h1);
    check("ovr_first_dout",  32'(dout),       32'h11);
    send_frame(8'h22, 1'b1);
    send_bit(1'b1);
    check("ovr_overrun_pulse", 32'(ov_cnt - b_ov), 32'h1);
    check("ovr_dout_held",     32'(dout),          32'h11);
    check("ovr_valid_held",    32'(dout_valid),    32'h1);

    // Ready arrives on exactly the edge that completes 0x33.
    snap();
    exp_q.push_back(8'h33);
    fork
      send_frame(8'h33, 1'b1);
      begin
        repeat (STOP_VOTE_EDGE - 1) @(posedge clk);
        #1 dout_ready = 1'b1;
        @(posedge clk);
        #1 dout_ready = 1'b0;
      end
    join
    send_bit(1'b1);
    check("same_edge_dout",    32'(dout),           32'h33);
    check("same_edge_valid",   32'(dout_valid),     32'h1);
    check("same_edge_overrun", 32'(ov_cnt - b_ov),  32'h0);
    check("same_edge_took_11", 32'(hs_cnt - b_hs),  32'h1);
    set_ready(1'b1);
    tick(2);
    check("drain_queue_empty", 32'(exp_q.size()), 32'h0);

    // Reset in the middle of bit 4 of 0xFF.
    snap();
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    rxd = 1'b1;
    tick(8);
    check("mid_frame_busy", 32'(busy), 32'h1);
    rst = 1'b1;
    #1;
    check("mid_rst_dout",  32'(dout),       32'h00);
    check("mid_rst_valid", 32'(dout_valid), 32'h0);
    check("mid_rst_busy",  32'(busy),       32'h0);
    tick(3);
    rst = 1'b0;
    tick(2 * CPB);
    check("after_rst_busy",  32'(busy),          32'h0);
    check("after_rst_bytes", 32'(hs_cnt - b_hs), 32'h0);
    exp_q.push_back(8'h81);
    send_frame(8'h81, 1'b1);
    send_bit(1'b1);
    check("after_rst_dout",    32'(dout),          32'h81);
    check("after_rst_bytes_1", 32'(hs_cnt - b_hs), 32'h1);

`ifdef UART_RX_PARITY_EN
    // 0x07 has three ones: parity bit 0 is wrong, 1 is right.
    snap();
    par_flip = 1'b1;
    send_frame(8'h07, 1'b1);
    send_bit(1'b1);
    check("par_bad_pulse",   32'(par_cnt - b_par), 32'h1);
    check("par_bad_bytes",   32'(hs_cnt - b_hs),   32'h0);
    check("par_bad_framing", 32'(fr_cnt - b_fr),   32'h0);
    par_flip = 1'b0;
    snap();
    exp_q.push_back(8'h07);
    send_frame(8'h07, 1'b1);
    send_bit(1'b1);
    check("par_good_pulse", 32'(par_cnt - b_par), 32'h0);
    check("par_good_bytes", 32'(hs_cnt - b_hs),   32'h1);
    check("par_good_dout",  32'(dout),            32'h07);
`endif

    // Randomized stream: outcome of each frame decided from the frame rules.
    begin
      int         e_fr = 0;
      int         e_par = 0;
      logic [7:0] d;
      logic       stop_b;
      logic       par_bad;
      int         gap;
      int         glen;
      snap();
      for (int f = 0; f < 40; f++) begin
        d       = 8'($urandom_range(0, 255));
        stop_b  = ($urandom_range(0, 5) != 0);
        par_bad = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bad  = ($urandom_range(0, 5) == 0);
        par_flip = par_bad;
`endif
        gap = $urandom_range(0, 3);
        if (!stop_b && gap == 0) gap = 1;
        if (!stop_b)       e_fr++;
        else if (par_bad)  e_par++;
        else               exp_q.push_back(d);
        send_frame(d, stop_b);
        if (gap == 3 && $urandom_range(0, 1) == 1) begin
          send_bit(1'b1);
          glen = $urandom_range(1, H - 2);
          rxd  = 1'b0;
          tick(glen);
          rxd  = 1'b1;
          tick(2 * CPB - glen);
        end else begin
          for (int g = 0; g < gap; g++) send_bit(1'b1);
        end
      end
`ifdef UART_RX_PARITY_EN
      par_flip = 1'b0;
`endif
      send_bit(1'b1);
      send_bit(1'b1);
      check("rand_queue_empty", 32'(exp_q.size()),    32'h0);
      check("rand_framing",     32'(fr_cnt - b_fr),   32'(e_fr));
      check("rand_parity",      32'(par_cnt - b_par), 32'(e_par));
      check("rand_overrun",     32'(ov_cnt - b_ov),   32'h0);
    end

`ifndef UART_RX_PARITY_EN
    check("parity_never_pulsed", 32'(par_cnt), 32'h0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
